pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the CPU fetch stage. It holds the architectural PC register and selects the next PC each cycle. Sources are the sequential path, conditional branch, J-type region jump, and register jump. It also keeps a return-address stack (RAS) that checks `jr` targets against the call history. It replaces the fixed 32-bit, purely combinational jump-address concatenation in the datapath and adds stall, a configurable width, and call/return tracking.

## Interface
Parameters:
- `WIDTH`, 32, PC/address width; legal range 30..64.
- `RESET_PC`, 0, PC value loaded on reset; must be word-aligned.
- `RAS_DEPTH`, 4, return-address stack entries; power of two, 2..16.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold PC and RAS this cycle.
- `sel`  in  2  next-PC source: 00 seq, 01 branch, 10 jump, 11 jr.
- `branch_taken`  in  1  branch condition, used only when `sel`=01.
- `imm16`  in  16  branch offset in words, signed.
- `target26`  in  26  J-type word address.
- `reg_target`  in  WIDTH  register value for `jr`/`jalr`.
- `is_call`  in  1  link instruction (`jal`/`jalr`); push return address.
- `is_ret`  in  1  return (`jr $ra`); pop RAS.
- `pc`  out  WIDTH  current PC (registered).
- `pc_plus4`  out  WIDTH  `pc`+4 (combinational, wraps modulo 2^WIDTH).
- `ras_empty`  out  1  RAS count = 0.
- `ras_full`  out  1  RAS count = `RAS_DEPTH`.
- `ras_overflow`  out  1  one-cycle pulse: a push overwrote the oldest entry.
- `ras_underflow`  out  1  one-cycle pulse: a pop on an empty RAS.
- `ras_mismatch`  out  1  one-cycle pulse: a return target differed from the RAS top.
- `addr_misalign`  out  1  one-cycle pulse: a `jr` target had low bits ≠ 00.

## Operation
- Next-PC computation, all arithmetic modulo 2^WIDTH:
  - 00: `pc_plus4`.
  - 01: if `branch_taken`, `pc_plus4` + (sign-extend(`imm16`) << 2); otherwise `pc_plus4`.
  - 10: {`pc_plus4`[WIDTH-1:28], `target26`, 2'b00}. The region bits come from PC+4, not PC.
  - 11: {`reg_target`[WIDTH-1:2], 2'b00}. If `reg_target`[1:0] ≠ 0, also pulse `addr_misalign`.
- `jr` always uses `reg_target`. The RAS never redirects fetch; it only checks.
- RAS is a circular buffer: top pointer plus count (0..`RAS_DEPTH`).
- Push (`is_call`, `sel` ∈ {10,11}):
  - Writes `pc_plus4` at top+1.
  - If full: the oldest entry is overwritten, count stays `RAS_DEPTH`, and `ras_overflow` pulses.
- Pop (`is_ret`, `sel`=11):
  - If count > 0: compare the top entry with the aligned `reg_target`; pulse `ras_mismatch` on inequality; then decrement.
  - If empty: state unchanged, `ras_underflow` pulses, no mismatch pulse.
- Push and pop in the same cycle (`jalr` used as a return): pop and compare first, then push `pc_plus4`.
  - Count unchanged if it was non-zero.
  - If it was empty: underflow pulses, then push; count = 1.
- `is_call`/`is_ret` with an inapplicable `sel` are ignored.
- `stall`=1: `pc`, RAS contents, pointer and count all hold, and all pulse outputs are 0 next cycle.

## Timing
- `pc` updates on the rising edge when `rst`=0 and `stall`=0; next-PC latency is one cycle.
- `pc_plus4`, `ras_empty` and `ras_full` are combinational from registered state.
- Pulse outputs are registered. They assert in the cycle after the triggering edge, i.e. alongside the new `pc`, for exactly one cycle.
- Reset (`rst`=1 at an edge), taking priority over `stall` and all other inputs:
  - `pc` = `RESET_PC`.
  - RAS count = 0 and pointer = 0; contents don't-care.
  - All pulse outputs = 0.
  - Therefore `ras_empty`=1 and `ras_full`=0.
- Reset mid-sequence discards any in-flight push/pop.
- PC wrap: 0xFFFFFFFC + 4 → 0x00000000 (WIDTH=32), with no flag.

## Test plan
- Reset then 3 sequential cycles: `pc` 0 → 4 → 8 → C; assert `rst` with `stall`=1 → `pc`=0, `ras_empty`=1.
- Branches at `pc`=0x100:
  - `imm16`=0xFFFF taken → 0x100.
  - `imm16`=0x0010 taken → 0x144.
  - Not taken → 0x104.
- Region jump at `pc`=0x3FFFFFFC with `target26`=0x0000010: next PC = 0x40000040, which tests the PC+4 region source.
- RAS_DEPTH=4 overflow and underflow:
  - Five `jal`: 4th push sets `ras_full`; 5th pulses `ras_overflow`.
  - Five matching `jr $ra`: no mismatch for the first four; 5th pulses `ras_underflow`.
- `jr` with `reg_target`=0x1003 and `is_ret` against a RAS top of 0x1000: next PC = 0x1000, `addr_misalign`=1, `ras_mismatch`=0.
- `stall` held 3 cycles during `jal`: `pc` and RAS count unchanged, no pulses; push happens on the first unstalled cycle.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-stage next-PC control bundle between the pipeline control (master)
// and the PC sequencer (slave).
//   stall/sel/branch_taken/imm16/target26/reg_target/is_call/is_ret : control in
//   pc/pc_plus4                                                     : PC out
//   ras_empty/ras_full                                              : RAS level
//   ras_overflow/ras_underflow/ras_mismatch/addr_misalign           : event pulses
interface pc_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic [1:0]       sel;
    logic             branch_taken;
    logic [15:0]      imm16;
    logic [25:0]      target26;
    logic [WIDTH-1:0] reg_target;
    logic             is_call;
    logic             is_ret;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_underflow;
    logic             ras_mismatch;
    logic             addr_misalign;

    modport master (
        output stall, sel, branch_taken, imm16, target26, reg_target, is_call, is_ret,
        input  pc, pc_plus4, ras_empty, ras_full,
               ras_overflow, ras_underflow, ras_mismatch, addr_misalign
    );

    modport slave (
        input  stall, sel, branch_taken, imm16, target26, reg_target, is_call, is_ret,
        output pc, pc_plus4, ras_empty, ras_full,
               ras_overflow, ras_underflow, ras_mismatch, addr_misalign
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch stage.
// Holds the architectural PC, selects the next PC (sequential, conditional
// branch, J-type region jump, register jump) and keeps a circular
// return-address stack that checks return targets against call history.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : pc_sequencer_if slave modport (controls in, PC and RAS status out)
module pc_sequencer #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned       RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    pc_sequencer_if.slave        bus
);
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    localparam logic [1:0] SEL_SEQ    = 2'b00;
    localparam logic [1:0] SEL_BRANCH = 2'b01;
    localparam logic [1:0] SEL_JUMP   = 2'b10;
    localparam logic [1:0] SEL_JR     = 2'b11;

    // Architectural state
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             mismatch_q;
    logic             misalign_q;

    // Combinational next-state
    logic [WIDTH-1:0] pc_plus4_c;
    logic [WIDTH-1:0] br_off_c;
    logic [WIDTH-1:0] jr_target_c;
    logic [WIDTH-1:0] next_pc_c;
    logic             do_push_c;
    logic             do_pop_c;
    logic [PTR_W-1:0] top_pop_c;
    logic [CNT_W-1:0] cnt_pop_c;
    logic [PTR_W-1:0] top_next_c;
    logic [CNT_W-1:0] cnt_next_c;
    logic             wr_en_c;
    logic [PTR_W-1:0] wr_addr_c;
    logic             overflow_c;
    logic             underflow_c;
    logic             mismatch_c;
    logic             misalign_c;

    // Next-PC source selection; all arithmetic wraps modulo 2^WIDTH
    always_comb begin
        pc_plus4_c  = pc_q + WIDTH'(4);
        br_off_c    = {{(WIDTH-18){bus.imm16[15]}}, bus.imm16, 2'b00};
        jr_target_c = {bus.reg_target[WIDTH-1:2], 2'b00};
        misalign_c  = 1'b0;
        next_pc_c   = pc_plus4_c;
        case (bus.sel)
            SEL_SEQ:    next_pc_c = pc_plus4_c;
            SEL_BRANCH: next_pc_c = bus.branch_taken ? (pc_plus4_c + br_off_c) : pc_plus4_c;
            // Region bits come from PC+4 so a jump in a region's last slot lands in the next region
            SEL_JUMP:   next_pc_c = {pc_plus4_c[WIDTH-1:28], bus.target26, 2'b00};
            SEL_JR: begin
                next_pc_c  = jr_target_c;
                misalign_c = (bus.reg_target[1:0] != 2'b00);
            end
            default:    next_pc_c = pc_plus4_c;
        endcase
    end

    // RAS update: pop-and-compare is resolved first, then any push lands on the popped state
    always_comb begin
        do_push_c   = bus.is_call && bus.sel[1];
        do_pop_c    = bus.is_ret && (bus.sel == SEL_JR);
        top_pop_c   = top_q;
        cnt_pop_c   = count_q;
        underflow_c = 1'b0;
        mismatch_c  = 1'b0;
        if (do_pop_c) begin
            if (count_q == CNT_W'(0)) begin
                underflow_c = 1'b1;
            end else begin
                mismatch_c = (ras_mem[top_q] != jr_target_c);
                top_pop_c  = top_q - PTR_W'(1);
                cnt_pop_c  = count_q - CNT_W'(1);
            end
        end

        top_next_c = top_pop_c;
        cnt_next_c = cnt_pop_c;
        wr_en_c    = 1'b0;
        wr_addr_c  = top_pop_c + PTR_W'(1);
        overflow_c = 1'b0;
        if (do_push_c) begin
            wr_en_c    = 1'b1;
            top_next_c = wr_addr_c;
            // When full, slot top+1 holds the oldest entry and is simply overwritten
            if (cnt_pop_c == CNT_FULL) begin
                overflow_c = 1'b1;
            end else begin
                cnt_next_c = cnt_pop_c + CNT_W'(1);
            end
        end
    end

    // PC, pointer, count and pulse registers; reset beats stall
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            top_q       <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else if (bus.stall) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            mismatch_q  <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= next_pc_c;
            top_q       <= top_next_c;
            count_q     <= cnt_next_c;
            overflow_q  <= overflow_c;
            underflow_q <= underflow_c;
            mismatch_q  <= mismatch_c;
            misalign_q  <= misalign_c;
        end
    end

    // RAS storage; contents are don't-care after reset so no reset term
    always_ff @(posedge clk) begin
        if (!rst && !bus.stall && wr_en_c) begin
            ras_mem[wr_addr_c] <= pc_plus4_c;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.pc_plus4      = pc_plus4_c;
    assign bus.ras_empty     = (count_q == CNT_W'(0));
    assign bus.ras_full      = (count_q == CNT_FULL);
    assign bus.ras_overflow  = overflow_q;
    assign bus.ras_underflow = underflow_q;
    assign bus.ras_mismatch  = mismatch_q;
    assign bus.addr_misalign = misalign_q;
endmodule
